pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Parametrised pipeline stage register for the 5-stage CPU (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   Carries a control bundle and a data payload with a valid/ready handshake.
//   A 2-entry skid buffer keeps in_ready registered, so stall timing is cut at every stage boundary.
//   A synchronous flush turns the stage into a bubble with control bits zeroed (NOP).
// PARAMETERS
//   CTRL_W      16  width of control bundle (EX/MEM/WB control bits)
//   DATA_W      32  width of data payload (PC+4, operands, ALU result, etc.)
//   CLR_DATA    0   1: flush/reset also zero the data registers; 0: data regs keep contents
// PORTS
//   sysclk     in   1        clock, rising edge
//   reset      in   1        asynchronous, active-low
//   flush      in   1        synchronous clear of stage contents (branch/jump/IRQ)
//   in_valid   in   1        upstream presents a beat
//   in_ready   out  1        stage accepts a beat this cycle (registered)
//   in_ctrl    in   CTRL_W   upstream control bundle
//   in_data    in   DATA_W   upstream payload
//   out_valid  out  1        stage presents a beat downstream
//   out_ready  in   1        downstream accepts (0 = stall from hazard unit)
//   out_ctrl   out  CTRL_W   control bundle; forced to 0 when out_valid=0
//   out_data   out  DATA_W   payload from main register
//   occupancy  out  2        number of beats held: 0, 1 or 2
// BEHAVIOUR
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Reset (async, reset=0): state EMPTY, out_valid=0, in_ready=1, occupancy=0, out_ctrl=0.
//     Main/skid ctrl regs are set to 0. Data regs are set to 0 only if CLR_DATA=1.
//   - Latency: an accepted beat appears on out_* the next cycle when the stage was EMPTY,
//     or when it was ONE and out_fire occurred. Throughput is 1 beat/cycle.
//   - States (main = output register, skid = overflow register):
//     EMPTY: in_fire -> ONE, main <= in.
//     ONE:   in_fire & out_fire  -> ONE, main <= in.
//            in_fire & !out_fire -> FULL, skid <= in.
//            !in_fire & out_fire -> EMPTY.
//            neither             -> ONE (hold).
//     FULL:  out_fire -> ONE, main <= skid. in_ready=0, so in_valid is ignored.
//            no out_fire -> hold.
//   - in_ready is 1 in EMPTY/ONE and 0 in FULL. It is computed from the next state and registered.
//   - out_valid = (state != EMPTY). occupancy: EMPTY=0, ONE=1, FULL=2.
//   - Flush has priority over every simultaneous event.
//     Next state is EMPTY, ctrl regs are zeroed, and any in_fire that cycle is discarded.
//     An out_fire in the same cycle is still a valid downstream transfer.
//     in_ready=1 the cycle after flush.
//   - Data ordering is strictly FIFO; no beat is lost or duplicated under any out_ready pattern.
//   - When out_valid=0, out_ctrl=0 (bubble) and out_data holds the last main value.
//   - Reset asserted mid-operation: both entries are dropped immediately (async).
//     No beat is presented until a new in_fire after reset deasserts.
// STRUCTURE
//   - Shared package cpu_pipe_pkg holds:
//     the state encoding (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2);
//     the per-stage CTRL_W constants (ID_EX_CTRL_W=16, EX_MEM_CTRL_W=5, MEM_WB_CTRL_W=3);
//     NOP_CTRL = '0.
//   - Single module, no sub-module: the main and skid regs plus a 2-bit state register fit in one block.
//   - Stage wrappers (ID/EX etc.) concatenate their fields into in_data/in_ctrl and instantiate this block.
// TESTING
//   1. Reset: pulse reset low while FULL -> out_valid=0, occupancy=0, in_ready=1, out_ctrl=0 asynchronously.
//   2. Streaming: out_ready=1, in_data 0x1,0x2,0x3 on consecutive cycles.
//      -> out_data 0x1,0x2,0x3 one cycle later, back-to-back, occupancy stays 1.
//   3. Backpressure: out_ready=0, drive A,B,C.
//      -> A on out, B in skid, in_ready=0, C held upstream.
//      Then out_ready=1 -> A,B,C in order, no duplicates.
//   4. Flush in FULL with in_valid=1 (ctrl=0xFFFF) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; input beat dropped.
//   5. ONE state, in_fire & out_fire same cycle -> occupancy stays 1 and out_data updates to the new beat.
//   6. Instance CTRL_W=3, DATA_W=8, CLR_DATA=1: randomised valid/ready against a scoreboard.
//      -> order preserved; data=0 after flush.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: the skid-buffer
// state encoding, the control-bundle widths of each stage boundary and the
// bubble (NOP) control value.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam int ID_EX_CTRL_W  = 16;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int MEM_WB_CTRL_W = 3;

    // Widest control bundle of a NOP; stages cast it down to their own width.
    localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

    // Number of beats held by a stage in a given state.
    function automatic logic [1:0] occupancy_of(input pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_FULL:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage : cpu_pipe_pkg

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer.
// The main register drives the stage outputs; the skid register catches the
// one beat that can arrive while the downstream stalls. That lets in_ready be
// a flop, which cuts the stall path at every stage boundary. A synchronous
// flush turns the stage into a bubble with NOP control bits.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int CTRL_W   = 16,
    parameter int DATA_W   = 32,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam logic [CTRL_W-1:0] STAGE_NOP = CTRL_W'(NOP_CTRL);

    pipe_state_t       state_q;
    pipe_state_t       state_nxt;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] skid_data_q;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    // Next-state and register-load decode; flush overrides every other event
    // and drops whatever beat is arriving in the same cycle.
    always_comb begin
        state_nxt      = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ST_ONE;
                        load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        state_nxt    = ST_ONE;
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = ST_FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_nxt      = ST_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State, registered in_ready and the control registers, which always
    // clear to NOP on reset and flush so a bubble never carries stale controls.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= STAGE_NOP;
            skid_ctrl_q <= STAGE_NOP;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != ST_FULL);
            if (flush) begin
                main_ctrl_q <= STAGE_NOP;
                skid_ctrl_q <= STAGE_NOP;
            end else begin
                if (load_main_in) begin
                    main_ctrl_q <= in_ctrl;
                end else if (load_main_skid) begin
                    main_ctrl_q <= skid_ctrl_q;
                end
                if (load_skid) begin
                    skid_ctrl_q <= in_ctrl;
                end
            end
        end
    end

    generate
        if (CLR_DATA) begin : g_clr_data
            // Data registers that also clear on reset and flush.
            always_ff @(posedge sysclk or negedge reset) begin
                if (!reset) begin
                    main_data_q <= '0;
                    skid_data_q <= '0;
                end else if (flush) begin
                    main_data_q <= '0;
                    skid_data_q <= '0;
                end else begin
                    if (load_main_in) begin
                        main_data_q <= in_data;
                    end else if (load_main_skid) begin
                        main_data_q <= skid_data_q;
                    end
                    if (load_skid) begin
                        skid_data_q <= in_data;
                    end
                end
            end
        end else begin : g_keep_data
            // Data registers without reset: contents are only meaningful
            // while out_valid is high, so they are left free of reset wiring.
            always_ff @(posedge sysclk) begin
                if (load_main_in) begin
                    main_data_q <= in_data;
                end else if (load_main_skid) begin
                    main_data_q <= skid_data_q;
                end
                if (load_skid) begin
                    skid_data_q <= in_data;
                end
            end
        end
    endgenerate

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl_q : STAGE_NOP;
    assign out_data  = main_data_q;
    assign occupancy = occupancy_of(state_q);

endmodule : pipe_stage_skid

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a directed vector table on the default-width
// instance, hand-written reset-while-full sequence, and a random valid/ready/
// flush run on a narrow CLR_DATA instance checked against a queue model.
module tb_pipe_stage_skid;

    logic        sysclk;
    logic        reset;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [2:0]  s_in_ctrl;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [2:0]  s_out_ctrl;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [15:0] in_ctrl;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_valid;
        logic [15:0] exp_ctrl;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic [1:0]  exp_occ;
    } vec_t;

    typedef struct packed {
        logic [2:0] c;
        logic [7:0] d;
    } ent_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    pipe_stage_skid #(
        .CTRL_W  (16),
        .DATA_W  (32),
        .CLR_DATA(1'b0)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(
        .CTRL_W  (3),
        .DATA_W  (8),
        .CLR_DATA(1'b1)
    ) dut_small (
        .sysclk   (sysclk),
        .reset    (reset),
        .flush    (s_flush),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_ctrl  (s_in_ctrl),
        .in_data  (s_in_data),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_ctrl (s_out_ctrl),
        .out_data (s_out_data),
        .occupancy(s_occupancy)
    );

    // Free-running 10-unit clock.
    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        flush     = v.flush;
        in_valid  = v.in_valid;
        in_ctrl   = v.in_ctrl;
        in_data   = v.in_data;
        out_ready = v.out_ready;
    endtask

    task automatic checkMain(input string tag, input logic ev, input logic [15:0] ec,
                             input logic [31:0] ed, input logic er, input logic [1:0] eo);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        checkOutput({tag, " out_ctrl"},  32'(out_ctrl),  32'(ec));
        checkOutput({tag, " out_data"},  out_data,       ed);
        checkOutput({tag, " in_ready"},  32'(in_ready),  32'(er));
        checkOutput({tag, " occupancy"}, 32'(occupancy), 32'(eo));
    endtask

    initial begin
        ent_t        q[$];
        logic [7:0]  held;
        logic        m_fire_in;
        logic        m_fire_out;
        ent_t        e;

        // flush, in_valid, in_ctrl, in_data, out_ready -> valid, ctrl, data, ready, occ
        // streaming 1,2,3 with out_ready=1 (also in_fire & out_fire in ONE)
        vecs[0]  = '{1'b0, 1'b1, 16'h0011, 32'h1, 1'b1, 1'b1, 16'h0011, 32'h1, 1'b1, 2'd1};
        vecs[1]  = '{1'b0, 1'b1, 16'h0022, 32'h2, 1'b1, 1'b1, 16'h0022, 32'h2, 1'b1, 2'd1};
        vecs[2]  = '{1'b0, 1'b1, 16'h0033, 32'h3, 1'b1, 1'b1, 16'h0033, 32'h3, 1'b1, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 16'h0000, 32'h3, 1'b1, 2'd0};
        // backpressure A,B,C: C held upstream while FULL, then drained in order
        vecs[4]  = '{1'b0, 1'b1, 16'h0A0A, 32'hA, 1'b0, 1'b1, 16'h0A0A, 32'hA, 1'b1, 2'd1};
        vecs[5]  = '{1'b0, 1'b1, 16'h0B0B, 32'hB, 1'b0, 1'b1, 16'h0A0A, 32'hA, 1'b0, 2'd2};
        vecs[6]  = '{1'b0, 1'b1, 16'h0C0C, 32'hC, 1'b0, 1'b1, 16'h0A0A, 32'hA, 1'b0, 2'd2};
        vecs[7]  = '{1'b0, 1'b1, 16'h0C0C, 32'hC, 1'b1, 1'b1, 16'h0B0B, 32'hB, 1'b1, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 16'h0C0C, 32'hC, 1'b1, 1'b1, 16'h0C0C, 32'hC, 1'b1, 2'd1};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 16'h0000, 32'hC, 1'b1, 2'd0};
        // flush while FULL with a beat offered: beat dropped, data kept (CLR_DATA=0)
        vecs[10] = '{1'b0, 1'b1, 16'h0D0D, 32'hD, 1'b0, 1'b1, 16'h0D0D, 32'hD, 1'b1, 2'd1};
        vecs[11] = '{1'b0, 1'b1, 16'h0E0E, 32'hE, 1'b0, 1'b1, 16'h0D0D, 32'hD, 1'b0, 2'd2};
        vecs[12] = '{1'b1, 1'b1, 16'hFFFF, 32'hF, 1'b0, 1'b0, 16'h0000, 32'hD, 1'b1, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 16'h0000, 32'hD, 1'b1, 2'd0};
        // flush in ONE together with out_fire and in_fire
        vecs[14] = '{1'b0, 1'b1, 16'h0707, 32'h7, 1'b1, 1'b1, 16'h0707, 32'h7, 1'b1, 2'd1};
        vecs[15] = '{1'b1, 1'b1, 16'h0808, 32'h8, 1'b1, 1'b0, 16'h0000, 32'h7, 1'b1, 2'd0};
        vecs[16] = '{1'b0, 1'b1, 16'h0909, 32'h9, 1'b1, 1'b1, 16'h0909, 32'h9, 1'b1, 2'd1};
        vecs[17] = '{1'b0, 1'b1, 16'h0606, 32'h6, 1'b0, 1'b1, 16'h0909, 32'h9, 1'b0, 2'd2};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b1, 16'h0606, 32'h6, 1'b1, 2'd1};
        vecs[19] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 16'h0000, 32'h6, 1'b1, 2'd0};

        reset = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = '0; s_in_data = '0; s_out_ready = 1'b0;
        #12;
        reset = 1'b1;
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_ctrl",  32'(out_ctrl),  32'd0);
        checkOutput("reset in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset occupancy", 32'(occupancy), 32'd0);
        checkOutput("reset small data", 32'(s_out_data), 32'd0);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkMain($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_ctrl,
                      vecs[i].exp_data, vecs[i].exp_ready, vecs[i].exp_occ);
        end

        // Fill to FULL, then pull reset mid-cycle and look before any edge.
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        in_ctrl = 16'h1111; in_data = 32'h11;
        tick();
        in_ctrl = 16'h2222; in_data = 32'h22;
        tick();
        checkOutput("prefill occupancy", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("async reset occupancy", 32'(occupancy), 32'd0);
        checkOutput("async reset in_ready",  32'(in_ready),  32'd1);
        checkOutput("async reset out_ctrl",  32'(out_ctrl),  32'd0);
        @(posedge sysclk);
        #3;
        reset = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("post reset idle valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_ctrl = 16'h3333; in_data = 32'h33;
        tick();
        checkMain("post reset beat", 1'b1, 16'h3333, 32'h33, 1'b1, 2'd1);
        in_valid = 1'b0;
        tick();
        checkMain("post reset drain", 1'b0, 16'h0000, 32'h33, 1'b1, 2'd0);

        // Random valid/ready/flush traffic on the narrow instance.
        held = 8'h00;
        for (int i = 0; i < 400; i++) begin
            checkOutput("rnd out_valid", 32'(s_out_valid), 32'(q.size() > 0));
            checkOutput("rnd in_ready",  32'(s_in_ready),  32'(q.size() < 2));
            checkOutput("rnd occupancy", 32'(s_occupancy), 32'(q.size()));
            checkOutput("rnd out_ctrl",  32'(s_out_ctrl),  (q.size() > 0) ? 32'(q[0].c) : 32'd0);
            checkOutput("rnd out_data",  32'(s_out_data),  (q.size() > 0) ? 32'(q[0].d) : 32'(held));

            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_out_ready = ($urandom_range(0, 2) != 0);
            s_flush     = ($urandom_range(0, 15) == 0);
            s_in_ctrl   = 3'($urandom_range(0, 7));
            s_in_data   = 8'($urandom_range(0, 255));

            m_fire_in  = s_in_valid && (q.size() < 2);
            m_fire_out = (q.size() > 0) && s_out_ready;
            if (m_fire_out) begin
                void'(q.pop_front());
            end
            if (s_flush) begin
                q.delete();
                held = 8'h00;
            end else if (m_fire_in) begin
                e.c = s_in_ctrl;
                e.d = s_in_data;
                q.push_back(e);
            end
            if (q.size() > 0) begin
                held = q[0].d;
            end
            tick();
        end
        s_in_valid = 1'b0; s_flush = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_stage_skid
